// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a shared data memory.
// m0 (CPU load/store) and m1 (loader/debug) are served round-robin, one access at a time:
// grant in IDLE, one memory strobe in ACCESS, one response pulse in RESP.
// Out-of-range, misaligned and unsupported-size accesses never reach the memory
// and are answered with err=1.
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  // Port 0: CPU
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_funct3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // Port 1: loader / debug
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_funct3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // Memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic        prio_q;        // port that wins a tie: 0 = m0, 1 = m1
  logic        cmd_port_q;
  logic        cmd_we_q;
  logic        cmd_err_q;
  logic [2:0]  cmd_funct3_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;

  logic        win0;
  logic        win1;
  logic        sel_we;
  logic [2:0]  sel_funct3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] sel_last;      // last byte touched, one bit wider so it cannot wrap
  logic        sel_illegal;
  logic        strobe;
  logic [31:0] resp_data;

  // Pick the winner among the requesters and classify its command.
  always_comb begin
    win0       = m0_req & (~m1_req | ~prio_q);
    win1       = m1_req & ~win0;
    sel_we     = win1 ? m1_we     : m0_we;
    sel_funct3 = win1 ? m1_funct3 : m0_funct3;
    sel_addr   = win1 ? m1_addr   : m0_addr;
    sel_wdata  = win1 ? m1_wdata  : m0_wdata;

    sel_last = {1'b0, sel_addr};
    case (sel_funct3[1:0])
      2'b01:        sel_last = {1'b0, sel_addr} + 33'd1;
      2'b10, 2'b11: sel_last = {1'b0, sel_addr} + 33'd3;
      default:      ;
    endcase

    sel_illegal = (sel_last >= 33'(MEM_SIZE))
                | ((sel_funct3[1:0] == 2'b01) & sel_addr[0])
                | ((sel_funct3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00))
                | (sel_we & (sel_funct3 > 3'b010))
                | (~sel_we & ((sel_funct3 == 3'b011) | (sel_funct3[2:1] == 2'b11)));
  end

  // Grants are combinational and only offered while idle and out of reset.
  assign m0_gnt = rst_n & (state_q == StIdle) & win0;
  assign m1_gnt = rst_n & (state_q == StIdle) & win1;

  // Memory command comes only from the latched command; zero when no strobe.
  assign strobe     = (state_q == StAccess) & ~cmd_err_q;
  assign mem_read   = strobe & ~cmd_we_q;
  assign mem_write  = strobe & cmd_we_q;
  assign mem_funct3 = strobe ? cmd_funct3_q : 3'b000;
  assign mem_addr   = strobe ? cmd_addr_q   : 32'd0;
  assign mem_wdata  = strobe ? cmd_wdata_q  : 32'd0;

  // Only a legal load returns memory data; stores and rejected accesses return zero.
  assign resp_data = (cmd_we_q | cmd_err_q) ? 32'd0 : mem_rdata;

  // Arbitration FSM: latch the winner, run one memory cycle, pulse the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      cmd_port_q   <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_funct3_q <= 3'b000;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      m0_rvalid    <= 1'b0;
      m0_rdata     <= 32'd0;
      m0_err       <= 1'b0;
      m1_rvalid    <= 1'b0;
      m1_rdata     <= 32'd0;
      m1_err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win0 | win1) begin
            state_q      <= StAccess;
            prio_q       <= win0;  // hand priority to the port that lost this round
            cmd_port_q   <= win1;
            cmd_we_q     <= sel_we;
            cmd_err_q    <= sel_illegal;
            cmd_funct3_q <= sel_funct3;
            cmd_addr_q   <= sel_addr;
            cmd_wdata_q  <= sel_wdata;
          end
        end
        StAccess: begin
          state_q <= StResp;
          if (cmd_port_q) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= resp_data;
            m1_err    <= cmd_err_q;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= resp_data;
            m0_err    <= cmd_err_q;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          m0_rvalid <= 1'b0;
          m0_rdata  <= 32'd0;
          m0_err    <= 1'b0;
          m1_rvalid <= 1'b0;
          m1_rdata  <= 32'd0;
          m1_err    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 4096, byte capacity of the shared data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req, m1_req  input  1 each  access request; m0 = CPU load/store, m1 = loader/debug port.
REQ-005 mX_we  input  1  1 = store, 0 = load.
REQ-006 mX_funct3  input  3  RV32I size code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 mX_addr  input  32  byte address.
REQ-008 mX_wdata  input  32  store data, LSBs used for b/h.
REQ-009 mX_gnt  output  1  request accepted this cycle.
REQ-010 mX_rvalid  output  1  one-cycle response pulse.
REQ-011 mX_rdata  output  32  load data, valid with rvalid.
REQ-012 mX_err  output  1  access rejected, valid with rvalid.
REQ-013 mem_read, mem_write  output  1 each  memory strobes.
REQ-014 mem_funct3  output  3; mem_addr  output  32; mem_wdata  output  32  memory command.
REQ-015 mem_rdata  input  32  combinational read data from the memory.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-017 Arbitration only in IDLE; mX_gnt is combinational, high only when state=IDLE and mX_req=1 and mX wins.
REQ-018 Single requester wins unconditionally; both requesting -> winner is the port named by the priority pointer.
REQ-019 Priority pointer flips to the non-granted port after each grant (round-robin).
REQ-020 On the grant edge, the winner's we/funct3/addr/wdata and port id are latched; requester may change inputs after gnt.
REQ-021 Request must be held until gnt; a req dropped before gnt has no effect.
REQ-022 ACCESS: exactly one of mem_read/mem_write high for one cycle, driven from latched command, unless the access is illegal.
REQ-023 ACCESS: mem_rdata registered at end of ACCESS for loads.
REQ-024 RESP: rvalid=1 for the latched port only; rdata = captured data for loads, 0 for stores.
REQ-025 Latency: req+gnt in cycle N -> memory strobe cycle N+1 -> rvalid cycle N+2; next grant earliest cycle N+3.
REQ-026 Illegal access: addr+size-1 >= MEM_SIZE (32-bit compare, no wrap), halfword with addr[0]=1, word with addr[1:0]!=0, store funct3 > 010, load funct3 in {011,110,111}.
REQ-027 Illegal access: no memory strobe in ACCESS; RESP gives rvalid=1, err=1, rdata=0.
REQ-028 err=0 on every legal response.
REQ-029 Memory command outputs are 0 whenever no strobe is asserted.
REQ-030 No combinational path from mem_rdata to any output.

Reset
REQ-031 rst_n low forces immediately: state IDLE, pointer -> m0, all outputs 0, latched command and captured data 0.
REQ-032 Reset during ACCESS aborts the access: mem_write drops asynchronously and no response is issued.
REQ-033 After rst_n rises, the first grant occurs in the first cycle with a request.

Verification
REQ-034 m0 sw addr 0x10 data 0xDEADBEEF, then m0 lw 0x10 -> first: write strobe at N+1, rvalid N+2 rdata 0; second: rdata 0xDEADBEEF, err 0.
REQ-035 m0 and m1 request together after reset, held -> m0 granted first, m1 granted 3 cycles later; repeated contention alternates.
REQ-036 m1 lh addr 0x0FFF (MEM_SIZE 4096) -> no mem_read, m1_rvalid=1, err=1, rdata 0.
REQ-037 m0 lw addr 0x102 -> misaligned: err=1, no strobe; m0 sb addr 0x103 data 0x80 then lb 0x103 -> rdata 0xFFFFFF80; lbu -> 0x00000080.
REQ-038 rst_n low during ACCESS of a store -> mem_write falls with rst_n, no rvalid, state IDLE, pointer m0.
REQ-039 m1 asserts req for one cycle while m0 is being served -> m1 never granted, no m1 response.
